// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: step-strobed 8-LED pattern sequencer with four modes, pause,
// and mode changes deferred to step boundaries.
module led_pattern_ctrl #(
  parameter int STEP_CYCLES = 500_000,
  parameter int CNT_W       = 19
) (
  input  logic       clk1MHz,
  input  logic       rst,
  input  logic       mode_req,
  input  logic [1:0] mode_sel,
  input  logic       pause,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       step_tick
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] led_q, led_d;
  logic [1:0] mode_q, mode_d, pend_m_q, pend_m_d, req_m;
  logic dir_q, dir_d, tick_q, tick_d, pend_v_q, pend_v_d, step, req_v;
  function automatic logic [7:0] seed(input logic [1:0] m);
    return m == 2'd1 ? 8'h80 : m == 2'd3 ? 8'hFF : 8'h01;
  endfunction
  always_comb begin
    step = !pause && cnt_q == CNT_W'(STEP_CYCLES - 1);
    req_v = mode_req || pend_v_q;
    req_m = mode_req ? mode_sel : pend_m_q;
    cnt_d = pause ? cnt_q : step ? '0 : cnt_q + CNT_W'(1);
    tick_d = step;
    pend_m_d = mode_req ? mode_sel : pend_m_q;
    pend_v_d = !step && req_v;
    mode_d = mode_q;
    led_d = led_q;
    dir_d = dir_q;
    if (step && req_v) begin
      mode_d = req_m;
      led_d = seed(req_m);
      dir_d = 1'b0;
    end else if (step) begin
      // a corrupted non-one-hot shift pattern self-heals by reseeding
      if (mode_q != 2'd3 && !$onehot(led_q)) led_d = seed(mode_q);
      else if (mode_q == 2'd0) led_d = {led_q[6:0], led_q[7]};
      else if (mode_q == 2'd1) led_d = {led_q[0], led_q[7:1]};
      else if (mode_q == 2'd3) led_d = ~led_q;
      else if (!dir_q) begin
        led_d = led_q == 8'h80 ? 8'h40 : led_q << 1;
        dir_d = led_q == 8'h80;
      end else begin
        led_d = led_q == 8'h01 ? 8'h02 : led_q >> 1;
        dir_d = led_q != 8'h01;
      end
    end
  end
  always_ff @(posedge clk1MHz or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      led_q <= 8'h01;
      mode_q <= 2'd0;
      dir_q <= 1'b0;
      tick_q <= 1'b0;
      pend_v_q <= 1'b0;
      pend_m_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
      mode_q <= mode_d;
      dir_q <= dir_d;
      tick_q <= tick_d;
      pend_v_q <= pend_v_d;
      pend_m_q <= pend_m_d;
    end
  end
  assign led = led_q;
  assign mode = mode_q;
  assign step_tick = tick_q;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed scenarios with a step-index reference model checked every cycle.
module tb_led_pattern_ctrl;
  localparam int SC = 4;
  logic clk1MHz = 1'b0, rst = 1'b1, mode_req = 1'b0, pause = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic [7:0] led;
  logic [1:0] mode;
  logic step_tick;
  int n_cmp = 0, n_err = 0;
  led_pattern_ctrl #(.STEP_CYCLES(SC), .CNT_W(2)) dut (
    .clk1MHz(clk1MHz), .rst(rst), .mode_req(mode_req), .mode_sel(mode_sel),
    .pause(pause), .led(led), .mode(mode), .step_tick(step_tick)
  );
  always #5 clk1MHz = ~clk1MHz;
  // model: the pattern is a pure function of the active mode and steps since it was seeded
  int m_cnt = 0, m_mode = 0, m_k = 0, m_pm = 0;
  bit m_pv = 0, m_tick = 0;
  function automatic logic [7:0] exp_led(int md, int k);
    int p;
    p = k % 14;
    if (md == 0) return 8'(1 << (k % 8));
    if (md == 1) return 8'(8'h80 >> (k % 8));
    if (md == 3) return (k % 2) ? 8'h00 : 8'hFF;
    return 8'(1 << (p <= 7 ? p : 14 - p));
  endfunction
  always @(posedge clk1MHz or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_mode = 0; m_k = 0; m_pm = 0; m_pv = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      if (!pause && m_cnt == SC - 1) begin
        m_tick = 1;
        m_cnt = 0;
        if (mode_req || m_pv) begin
          m_mode = mode_req ? int'(mode_sel) : m_pm;
          m_k = 0;
          m_pv = 0;
        end else m_k++;
      end else begin
        if (!pause) m_cnt++;
        if (mode_req) begin m_pv = 1; m_pm = int'(mode_sel); end
      end
    end
  end
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk1MHz) begin
    chk("model_led", int'(led), int'(exp_led(m_mode, m_k)));
    chk("model_mode", int'(mode), m_mode);
    chk("model_tick", int'(step_tick), int'(m_tick));
  end
  task automatic wait_tick(output int n);
    n = 0;
    do begin @(negedge clk1MHz); n++; end while (!step_tick && n < 40);
    if (!step_tick) chk("tick_timeout", n, -1);
  endtask
  logic [7:0] t1 [10] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
  logic [7:0] t2 [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                          8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
  initial begin
    int n;
    repeat (2) @(negedge clk1MHz);
    chk("rst_led", int'(led), 8'h01);
    chk("rst_mode", int'(mode), 0);
    chk("rst_tick", int'(step_tick), 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_tick(n);
      chk("t1_period", n, 4);
      chk("t1_led", int'(led), int'(t1[i]));
    end
    chk("t1_mode", int'(mode), 0);
    mode_req = 1'b1; mode_sel = 2'd2;
    @(negedge clk1MHz) mode_req = 1'b0;
    wait_tick(n);
    chk("t2_seed", int'(led), 8'h01);
    chk("t2_mode", int'(mode), 2);
    for (int i = 0; i < 16; i++) begin
      wait_tick(n);
      chk("t2_led", int'(led), int'(t2[i]));
    end
    @(negedge clk1MHz) begin mode_req = 1'b1; mode_sel = 2'd1; end
    @(negedge clk1MHz) mode_sel = 2'd3;
    @(negedge clk1MHz) mode_req = 1'b0;
    wait_tick(n);
    chk("t3_mode", int'(mode), 3);
    chk("t3_led0", int'(led), 8'hFF);
    wait_tick(n);
    chk("t3_led1", int'(led), 8'h00);
    wait_tick(n);
    chk("t3_led2", int'(led), 8'hFF);
    mode_req = 1'b1; mode_sel = 2'd2;
    @(negedge clk1MHz) mode_req = 1'b0;
    @(negedge clk1MHz);
    @(negedge clk1MHz) begin mode_req = 1'b1; mode_sel = 2'd1; end
    @(negedge clk1MHz) mode_req = 1'b0;
    chk("t4_tick", int'(step_tick), 1);
    chk("t4_mode", int'(mode), 1);
    chk("t4_led", int'(led), 8'h80);
    @(negedge clk1MHz);
    @(negedge clk1MHz) pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk1MHz);
      if (i == 4) begin mode_req = 1'b1; mode_sel = 2'd3; end
      if (i == 5) mode_req = 1'b0;
    end
    chk("t5_frozen_led", int'(led), 8'h80);
    chk("t5_frozen_mode", int'(mode), 1);
    chk("t5_no_tick", int'(step_tick), 0);
    pause = 1'b0;
    wait_tick(n);
    chk("t5_resume", n, 2);
    chk("t5_led", int'(led), 8'hFF);
    chk("t5_mode", int'(mode), 3);
    mode_req = 1'b1; mode_sel = 2'd2;
    @(negedge clk1MHz) mode_req = 1'b0;
    wait_tick(n);
    for (int i = 0; i < 8; i++) wait_tick(n);
    chk("t6_bounce", int'(led), 8'h40);
    mode_req = 1'b1; mode_sel = 2'd3;
    @(negedge clk1MHz) mode_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_led", int'(led), 8'h01);
    chk("t6_rst_mode", int'(mode), 0);
    chk("t6_rst_tick", int'(step_tick), 0);
    @(negedge clk1MHz);
    @(negedge clk1MHz) rst = 1'b0;
    wait_tick(n);
    chk("t6_first_step", n, 4);
    chk("t6_led", int'(led), 8'h02);
    chk("t6_mode", int'(mode), 0);
    wait_tick(n);
    chk("t6_led2", int'(led), 8'h04);
    chk("t6_mode2", int'(mode), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Pattern sequencer for the 8-LED bank. Generates its own step strobe from the 1 MHz system clock and advances one of four LED patterns per step. Accepts runtime mode-change requests and a pause control, applying mode changes only on step boundaries so the display never shows a partial pattern. Sits directly above the LED outputs and replaces the fixed water-light generator in the board top.

## Interface
- STEP_CYCLES, 500_000: clk1MHz cycles per pattern step, ≥2 (500_000 gives 2 steps/s).
- CNT_W, 19: step counter width, must hold STEP_CYCLES-1.

- clk1MHz  in  1  system clock, 1 MHz; the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- mode_req  in  1  single-cycle request strobe, synchronous to clk1MHz.
- mode_sel  in  2  requested mode, sampled only when mode_req=1.
- pause  in  1  level, synchronous; 1 freezes the step counter and LEDs.
- led  out  8  LED drive, registered.
- mode  out  2  mode currently displayed, registered.
- step_tick  out  1  one-cycle pulse, high in the cycle after each step edge.

## Operation
- Modes:
  - 0: rotate left, seed 0x01.
  - 1: rotate right, seed 0x80.
  - 2: ping-pong, seed 0x01, direction left.
  - 3: blink, seed 0xFF, toggles 0xFF↔0x00.
- Reset values: led=0x01, mode=0, dir=left, cnt=0, step_tick=0, pending_valid=0, pending_mode=0.
- Step counter cnt runs 0..STEP_CYCLES-1 while pause=0 and holds while pause=1. A step edge is a clock edge where cnt==STEP_CYCLES-1 and pause=0; at that edge cnt returns to 0.
- Request capture: mode_req=1 loads pending_mode<=mode_sel and sets pending_valid. A later request before the next step edge overwrites the earlier one (last wins). Requests are accepted while paused.
- At each step edge:
  - Effective request: if mode_req=1 in that cycle, use mode_sel; otherwise use pending_mode when pending_valid=1.
  - If an effective request exists: mode<=request, led<=seed(request), dir<=left, pending_valid<=0. This applies even when the requested mode equals the current mode, which restarts the pattern.
  - Otherwise led<=next(mode, led, dir).
- Pattern rules:
  - Mode 0: led<={led[6:0],led[7]}.
  - Mode 1: led<={led[0],led[7:1]}.
  - Mode 2 (one-hot walk): left shifts up; at led==0x80, led<=0x40 and dir<=right. Right shifts down; at led==0x01, led<=0x02 and dir<=left. Ends are shown exactly once per bounce.
  - Mode 3: led<=~led.
- Defensive rule: in modes 0–2, if led is not one-hot, led<=seed(mode) on the next step edge.
- Controller states: RUN (pause=0) and HOLD (pause=1). These are implicit from pause; no extra delay on entry or exit. After pause falls, counting resumes from the held cnt value.

## Timing
- All state changes occur on posedge clk1MHz, except reset, which is asynchronous.
- led, mode and step_tick update on the same edge: the step edge.
- step_tick is high for exactly one cycle per step and never while paused.
- Reset deassertion: the first step edge occurs STEP_CYCLES edges later.
- Request latency: the request applies at the next step edge, anywhere from 0 to STEP_CYCLES-1 cycles plus any paused time. A request in the step-edge cycle itself applies at that edge.
- Reset mid-step or mid-bounce: all registers return to their reset values immediately; a pending request is discarded.
- pause=1 in the cycle where cnt==STEP_CYCLES-1: no step occurs; cnt stays at STEP_CYCLES-1 and the step fires on the first unpaused edge.

## Test plan
All scenarios use STEP_CYCLES=4.
- Reset then run 10 steps: led sequence 0x01,0x02,…,0x80,0x01,0x02; step_tick once every 4 cycles; mode=0.
- Apply mode_req with mode_sel=2, then run 16 steps: led 0x01,0x02,…,0x80,0x40,…,0x01,0x02; 0x80 and 0x01 each appear once per bounce.
- mode_req with mode_sel=1 at cnt=1, then mode_req with mode_sel=3 at cnt=2: at the next edge mode=3 and led=0xFF; the following step gives 0x00, then 0xFF. Mode 1 is never shown.
- mode_req in the cnt==3 cycle with mode_sel=1: at that edge mode=1 and led=0x80. A pending older request is overridden.
- Hold pause=1 for 10 cycles starting at cnt=2: led, cnt and mode frozen, step_tick stays 0, and a mode_req (sel=3) is accepted. After release, the step comes 2 cycles later with led=0xFF.
- Assert rst asynchronously mid-bounce in mode 2 with dir=right and a pending request: led=0x01, mode=0 and step_tick=0 immediately. After release, the first step gives led=0x02 and the pending request is never applied.
